// File: rtl/warp_completion_collector_pkg.sv
// Shared sizing and payload types for the warp dispatch return path.
package warp_completion_collector_pkg;

    localparam int unsigned NUM_SIMD_CORES  = 4;
    localparam int unsigned LOG2_SIMD_CORES = 2;
    localparam int unsigned WARP_ID_W       = 8;

    localparam logic [WARP_ID_W-1:0] INVALID_WARP_ID = '1;

    typedef struct packed {
        logic [WARP_ID_W-1:0] warp_id;
    } kernel_t;

endpackage

// File: rtl/warp_completion_collector_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module warp_completion_collector_rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = IW'(ptr + IW'(off));
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant_idx = idx;
            end
        end
        if (any_grant) begin
            grant = N'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/warp_completion_collector.sv
// Tracks busy SIMD cores, collects done pulses and returns freed cores one at a time
// to the dispatcher over a valid/ready slot.
module warp_completion_collector #(
    parameter int unsigned NUM_CORES = warp_completion_collector_pkg::NUM_SIMD_CORES,
    parameter int unsigned ID_W      = warp_completion_collector_pkg::LOG2_SIMD_CORES,
    parameter int unsigned WARP_ID_W = warp_completion_collector_pkg::WARP_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_valid,
    input  logic [ID_W-1:0]      disp_core_id,
    input  logic [WARP_ID_W-1:0] disp_warp_id,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 freed_valid,
    input  logic                 freed_ready,
    output logic [ID_W-1:0]      freed_core_id,
    output logic [WARP_ID_W-1:0] freed_warp_id,
    output logic [NUM_CORES-1:0] busy_mask,
    output logic [ID_W:0]        idle_count,
    output logic                 err_double_disp,
    output logic                 err_spurious
);

    import warp_completion_collector_pkg::*;

    localparam int unsigned CNT_W = ID_W + 1;

    logic [NUM_CORES-1:0] pending_q;
    logic [WARP_ID_W-1:0] warp_id_q [NUM_CORES];
    logic [ID_W-1:0]      rr_ptr_q;

    logic [NUM_CORES-1:0] busy_d;
    logic [NUM_CORES-1:0] pending_d;
    logic [WARP_ID_W-1:0] warp_id_d [NUM_CORES];
    logic [ID_W-1:0]      rr_ptr_d;
    logic                 freed_valid_d;
    logic [ID_W-1:0]      freed_core_id_d;
    logic [WARP_ID_W-1:0] freed_warp_id_d;
    logic                 err_double_disp_d;
    logic                 err_spurious_d;

    logic                 release_c;
    logic                 slot_free_c;
    logic [NUM_CORES-1:0] in_slot_c;
    logic [NUM_CORES-1:0] done_ok_c;

    logic [NUM_CORES-1:0] grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 any_grant;

    warp_completion_collector_rr_arbiter #(
        .N (NUM_CORES)
    ) u_rr_arbiter (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Next-state: done capture, slot load, release and dispatch, all from pre-edge state.
    always_comb begin
        busy_d            = busy_mask;
        pending_d         = pending_q;
        warp_id_d         = warp_id_q;
        rr_ptr_d          = rr_ptr_q;
        freed_valid_d     = freed_valid;
        freed_core_id_d   = freed_core_id;
        freed_warp_id_d   = freed_warp_id;
        err_double_disp_d = 1'b0;
        err_spurious_d    = 1'b0;

        release_c   = freed_valid && freed_ready;
        slot_free_c = !freed_valid || freed_ready;
        in_slot_c   = freed_valid ? (NUM_CORES'(1) << freed_core_id) : '0;
        // A core sitting in the output slot is busy but not pending; its done is still bogus.
        done_ok_c   = core_done & busy_mask & ~pending_q & ~in_slot_c;

        err_spurious_d = |(core_done & ~done_ok_c);
        pending_d      = pending_q | done_ok_c;

        if (release_c) begin
            busy_d[freed_core_id] = 1'b0;
        end

        if (slot_free_c) begin
            if (any_grant) begin
                freed_valid_d   = 1'b1;
                freed_core_id_d = grant_idx;
                freed_warp_id_d = warp_id_q[grant_idx];
                pending_d       = pending_d & ~grant;
                rr_ptr_d        = ID_W'(grant_idx + ID_W'(1));
            end else begin
                freed_valid_d = 1'b0;
            end
        end

        // Dispatch after release so a same-cycle redispatch keeps the core busy.
        if (disp_valid) begin
            if (!busy_mask[disp_core_id] || (release_c && (freed_core_id == disp_core_id))) begin
                busy_d[disp_core_id]    = 1'b1;
                warp_id_d[disp_core_id] = disp_warp_id;
            end else begin
                err_double_disp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_mask       <= '0;
            pending_q       <= '0;
            rr_ptr_q        <= '0;
            freed_valid     <= 1'b0;
            freed_core_id   <= '0;
            freed_warp_id   <= '1;
            err_double_disp <= 1'b0;
            err_spurious    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                warp_id_q[i] <= '1;
            end
        end else begin
            busy_mask       <= busy_d;
            pending_q       <= pending_d;
            rr_ptr_q        <= rr_ptr_d;
            freed_valid     <= freed_valid_d;
            freed_core_id   <= freed_core_id_d;
            freed_warp_id   <= freed_warp_id_d;
            err_double_disp <= err_double_disp_d;
            err_spurious    <= err_spurious_d;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                warp_id_q[i] <= warp_id_d[i];
            end
        end
    end

    // Idle core count straight off the registered busy mask.
    always_comb begin
        idle_count = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idle_count = idle_count + CNT_W'(!busy_mask[i]);
        end
    end

endmodule

// File: tb/tb_warp_completion_collector.sv
// Scoreboard bench for warp_completion_collector: expected freed cores are queued at stimulus time.
module tb_warp_completion_collector;

    import warp_completion_collector_pkg::*;

    localparam int unsigned NC = NUM_SIMD_CORES;
    localparam int unsigned IW = LOG2_SIMD_CORES;
    localparam int unsigned WW = WARP_ID_W;

    typedef struct packed {
        logic [IW-1:0] core;
        logic [WW-1:0] warp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          disp_valid = 1'b0;
    logic [IW-1:0] disp_core_id = '0;
    logic [WW-1:0] disp_warp_id = '0;
    logic [NC-1:0] core_done = '0;
    logic          freed_valid;
    logic          freed_ready = 1'b0;
    logic [IW-1:0] freed_core_id;
    logic [WW-1:0] freed_warp_id;
    logic [NC-1:0] busy_mask;
    logic [IW:0]   idle_count;
    logic          err_double_disp;
    logic          err_spurious;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    warp_completion_collector #(
        .NUM_CORES (NC),
        .ID_W      (IW),
        .WARP_ID_W (WW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .disp_valid      (disp_valid),
        .disp_core_id    (disp_core_id),
        .disp_warp_id    (disp_warp_id),
        .core_done       (core_done),
        .freed_valid     (freed_valid),
        .freed_ready     (freed_ready),
        .freed_core_id   (freed_core_id),
        .freed_warp_id   (freed_warp_id),
        .busy_mask       (busy_mask),
        .idle_count      (idle_count),
        .err_double_disp (err_double_disp),
        .err_spurious    (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int core, input int warp);
        exp_t e;
        e.core = IW'(core);
        e.warp = WW'(warp);
        sb_q.push_back(e);
    endtask

    task automatic dispatch(input int core, input int warp);
        disp_valid   = 1'b1;
        disp_core_id = IW'(core);
        disp_warp_id = WW'(warp);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic [NC-1:0] m);
        core_done = m;
        tick();
        core_done = '0;
    endtask

    // Every accepted transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && freed_valid && freed_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'(1), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("freed_core", 32'(freed_core_id), 32'(mon_e.core));
                check("freed_warp", 32'(freed_warp_id), 32'(mon_e.warp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        tick();
        tick();
        check("rst_busy", 32'(busy_mask), 32'(0));
        check("rst_idle", 32'(idle_count), 32'(4));
        check("rst_valid", 32'(freed_valid), 32'(0));
        check("rst_warp", 32'(freed_warp_id), 32'hff);
        check("rst_errs", 32'({err_double_disp, err_spurious}), 32'(0));
        rst = 1'b1;
        tick();

        // Single warp on core 2
        freed_ready = 1'b1;
        dispatch(2, 8'h15);
        check("t2_busy", 32'(busy_mask), 32'(4'b0100));
        check("t2_idle", 32'(idle_count), 32'(3));
        tick();
        tick();
        push(2, 8'h15);
        done_pulse(4'b0100);
        check("t2_lat_early", 32'(freed_valid), 32'(0));
        tick();
        check("t2_valid", 32'(freed_valid), 32'(1));
        check("t2_core", 32'(freed_core_id), 32'(2));
        check("t2_warp", 32'(freed_warp_id), 32'h15);
        tick();
        check("t2_busy_after", 32'(busy_mask), 32'(0));
        check("t2_valid_after", 32'(freed_valid), 32'(0));

        // Reset in the middle of traffic drops everything
        freed_ready = 1'b0;
        dispatch(0, 8'h01);
        dispatch(1, 8'h02);
        done_pulse(4'b0011);
        tick();
        check("t1_slot_loaded", 32'(freed_valid), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        check("t1_async_valid", 32'(freed_valid), 32'(0));
        check("t1_async_busy", 32'(busy_mask), 32'(0));
        check("t1_async_core", 32'(freed_core_id), 32'(0));
        check("t1_async_warp", 32'(freed_warp_id), 32'hff);
        tick();
        rst = 1'b1;
        freed_ready = 1'b1;
        tick();
        tick();
        check("t1_post_valid", 32'(freed_valid), 32'(0));
        check("t1_post_busy", 32'(busy_mask), 32'(0));
        check("t1_post_idle", 32'(idle_count), 32'(4));

        // Round-robin drain from pointer 0
        for (int i = 0; i < 4; i++) dispatch(i, 8'h40 + i);
        check("t3_all_busy", 32'(idle_count), 32'(0));
        for (int i = 0; i < 4; i++) push(i, 8'h40 + i);
        done_pulse(4'b1111);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_rr_valid", 32'(freed_valid), 32'(1));
        end
        tick();
        check("t3_drained", 32'(freed_valid), 32'(0));
        check("t3_busy", 32'(busy_mask), 32'(0));

        // Move pointer to 2, then drain again: order 2,3,0,1
        dispatch(1, 8'h51);
        push(1, 8'h51);
        done_pulse(4'b0010);
        tick();
        tick();
        for (int i = 0; i < 4; i++) dispatch(i, 8'h60 + i);
        push(2, 8'h62);
        push(3, 8'h63);
        push(0, 8'h60);
        push(1, 8'h61);
        done_pulse(4'b1111);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3b_rr_valid", 32'(freed_valid), 32'(1));
        end
        tick();
        check("t3b_busy", 32'(busy_mask), 32'(0));

        // Backpressure holds the payload stable
        freed_ready = 1'b0;
        dispatch(0, 8'h70);
        dispatch(1, 8'h71);
        push(0, 8'h70);
        push(1, 8'h71);
        done_pulse(4'b0001);
        tick();
        done_pulse(4'b0001);
        check("t4_done_in_slot", 32'(err_spurious), 32'(1));
        done_pulse(4'b0010);
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", 32'(freed_valid), 32'(1));
            check("t4_hold_core", 32'(freed_core_id), 32'(0));
            check("t4_hold_warp", 32'(freed_warp_id), 32'h70);
            tick();
        end
        freed_ready = 1'b1;
        tick();
        check("t4_next_valid", 32'(freed_valid), 32'(1));
        check("t4_next_core", 32'(freed_core_id), 32'(1));
        check("t4_next_warp", 32'(freed_warp_id), 32'h71);
        tick();
        check("t4_busy", 32'(busy_mask), 32'(0));

        // Error pulses
        dispatch(3, 8'h33);
        check("t5_busy3", 32'(busy_mask), 32'(4'b1000));
        dispatch(3, 8'h99);
        check("t5_dbl_pulse", 32'(err_double_disp), 32'(1));
        tick();
        check("t5_dbl_clear", 32'(err_double_disp), 32'(0));
        push(3, 8'h33);
        done_pulse(4'b1000);
        tick();
        tick();
        check("t5_busy_after", 32'(busy_mask), 32'(0));
        done_pulse(4'b0001);
        check("t5_spur_pulse", 32'(err_spurious), 32'(1));
        check("t5_spur_novalid", 32'(freed_valid), 32'(0));
        tick();
        check("t5_spur_clear", 32'(err_spurious), 32'(0));
        check("t5_spur_novalid2", 32'(freed_valid), 32'(0));

        // Dispatch and done to the same idle core in one cycle
        disp_valid   = 1'b1;
        disp_core_id = IW'(2);
        disp_warp_id = WW'(8'h22);
        core_done    = 4'b0100;
        tick();
        disp_valid = 1'b0;
        core_done  = '0;
        check("t5_dd_spur", 32'(err_spurious), 32'(1));
        check("t5_dd_busy", 32'(busy_mask), 32'(4'b0100));
        tick();
        check("t5_dd_novalid", 32'(freed_valid), 32'(0));
        push(2, 8'h22);
        done_pulse(4'b0100);
        tick();
        tick();
        check("t5_dd_busy_after", 32'(busy_mask), 32'(0));

        // Same-cycle release and redispatch of core 1
        freed_ready = 1'b0;
        dispatch(1, 8'h11);
        push(1, 8'h11);
        done_pulse(4'b0010);
        tick();
        freed_ready = 1'b1;
        dispatch(1, 8'h2A);
        check("t6_no_err", 32'(err_double_disp), 32'(0));
        check("t6_busy", 32'(busy_mask), 32'(4'b0010));
        check("t6_novalid", 32'(freed_valid), 32'(0));
        push(1, 8'h2A);
        done_pulse(4'b0010);
        tick();
        check("t6_warp", 32'(freed_warp_id), 32'h2A);
        tick();
        check("t6_busy_after", 32'(busy_mask), 32'(0));

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
